// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and colour-field positions for the VGA
// timing block and its pixel-clock divider.
package vga_pkg;

    localparam int CLK_DIV   = 4;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Sync windows are half-open: START <= count < END.
    localparam int HS_START  = H_DISPLAY + H_FRONT;
    localparam int HS_END    = HS_START + H_SYNC;
    localparam int VS_START  = V_DISPLAY + V_FRONT;
    localparam int VS_END    = VS_START + V_SYNC;

    localparam int BLUE_MSB  = 7;
    localparam int BLUE_LSB  = 6;
    localparam int GREEN_MSB = 5;
    localparam int GREEN_LSB = 3;
    localparam int RED_MSB   = 2;
    localparam int RED_LSB   = 0;

    localparam int COORD_W   = 11;
    typedef logic [COORD_W-1:0] coord_t;

    function automatic logic in_window(input coord_t v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate enable: a free-running modulo-CLK_DIV counter whose terminal
// count is decoded straight from the register as a one-clock pix_tick.
module vga_pix_div #(
    parameter int CLK_DIV = vga_pkg::CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic pix_tick
);
    import vga_pkg::*;

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign pix_tick = (count == LAST);

endmodule

// File: rtl/vga_timing.sv
// VGA raster generator: walks (x, y) over the full frame at the pixel rate and
// drives registered sync and blanked colour pins one pixel behind the counters.
module vga_timing #(
    parameter int CLK_DIV   = vga_pkg::CLK_DIV,
    parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_pkg::H_FRONT,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BACK    = vga_pkg::H_BACK,
    parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    rgb_in,
    output logic [vga_pkg::COORD_W-1:0]   x,
    output logic [vga_pkg::COORD_W-1:0]   y,
    output logic                          pix_tick,
    output logic                          video_on,
    output logic                          frame_start,
    output logic                          hsync,
    output logic                          vsync,
    output logic [2:0]                    red,
    output logic [2:0]                    green,
    output logic [1:0]                    blue
);
    import vga_pkg::*;

    localparam int LINE_LEN    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int FRAME_LINES = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_FIRST    = H_DISPLAY + H_FRONT;
    localparam int HS_LIMIT    = HS_FIRST + H_SYNC;
    localparam int VS_FIRST    = V_DISPLAY + V_FRONT;
    localparam int VS_LIMIT    = VS_FIRST + V_SYNC;

    localparam coord_t X_LAST  = coord_t'(LINE_LEN - 1);
    localparam coord_t Y_LAST  = coord_t'(FRAME_LINES - 1);

    logic hs_c;
    logic vs_c;
    logic line_end;
    logic frame_end;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk      (clk),
        .reset    (reset),
        .pix_tick (pix_tick)
    );

    assign line_end  = (x == X_LAST);
    assign frame_end = line_end && (y == Y_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (pix_tick) begin
            if (line_end) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + coord_t'(1);
            end else begin
                x <= x + coord_t'(1);
            end
        end
    end

    // Decode on the live counters; the output stage below adds the one-pixel lag.
    always_comb begin
        video_on = (x < coord_t'(H_DISPLAY)) && (y < coord_t'(V_DISPLAY));
        hs_c     = in_window(x, HS_FIRST, HS_LIMIT);
        vs_c     = in_window(y, VS_FIRST, VS_LIMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_tick && frame_end;
            if (pix_tick) begin
                hsync <= ~hs_c;
                vsync <= ~vs_c;
                red   <= video_on ? rgb_in[RED_MSB:RED_LSB]     : '0;
                green <= video_on ? rgb_in[GREEN_MSB:GREEN_LSB] : '0;
                blue  <= video_on ? rgb_in[BLUE_MSB:BLUE_LSB]   : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a full-size instance and a shrunken-raster instance,
// checked against an arithmetic raster model plus directed corner sequences.
module tb_vga_timing;

    localparam int DA = 4;
    localparam int HDA = 640, HFA = 16, HSA = 96, HBA = 48;
    localparam int VDA = 480, VFA = 10, VSA = 2, VBA = 33;

    localparam int DB = 3;
    localparam int HDB = 8, HFB = 2, HSB = 3, HBB = 2;
    localparam int VDB = 5, VFB = 1, VSB = 2, VBB = 1;
    localparam int FRAME_CLK_B = (HDB + HFB + HSB + HBB) * (VDB + VFB + VSB + VBB) * DB;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        tick;
        logic        von;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [7:0]  col;
    } obs_t;

    typedef struct {
        logic [10:0] tx;
        logic [7:0]  rgb;
        logic [2:0]  r;
        logic [2:0]  g;
        logic [1:0]  b;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rgb_in = 8'h00;

    logic [10:0] x_a, y_a, x_b, y_b;
    logic        tick_a, von_a, fs_a, hsync_a, vsync_a;
    logic        tick_b, von_b, fs_b, hsync_b, vsync_b;
    logic [2:0]  red_a, green_a, red_b, green_b;
    logic [1:0]  blue_a, blue_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing dut_a (
        .clk(clk), .reset(reset), .rgb_in(rgb_in),
        .x(x_a), .y(y_a), .pix_tick(tick_a), .video_on(von_a),
        .frame_start(fs_a), .hsync(hsync_a), .vsync(vsync_a),
        .red(red_a), .green(green_a), .blue(blue_a)
    );

    vga_timing #(
        .CLK_DIV(DB), .H_DISPLAY(HDB), .H_FRONT(HFB), .H_SYNC(HSB), .H_BACK(HBB),
        .V_DISPLAY(VDB), .V_FRONT(VFB), .V_SYNC(VSB), .V_BACK(VBB)
    ) dut_b (
        .clk(clk), .reset(reset), .rgb_in(rgb_in),
        .x(x_b), .y(y_b), .pix_tick(tick_b), .video_on(von_b),
        .frame_start(fs_b), .hsync(hsync_b), .vsync(vsync_b),
        .red(red_b), .green(green_b), .blue(blue_b)
    );

    function automatic obs_t obs_a();
        return '{x_a, y_a, tick_a, von_a, fs_a, hsync_a, vsync_a, {blue_a, green_a, red_a}};
    endfunction

    function automatic obs_t obs_b();
        return '{x_b, y_b, tick_b, von_b, fs_b, hsync_b, vsync_b, {blue_b, green_b, red_b}};
    endfunction

    // Expected outputs after e clock edges since reset release. Pixel p is the
    // number of ticks taken so far; pins show the previous pixel and the colour
    // that was sampled on the most recent tick.
    function automatic obs_t model(input int e, input int d,
                                   input int hd, input int hf, input int hsw, input int hb,
                                   input int vd, input int vf, input int vsw, input int vb,
                                   input logic [7:0] smp);
        int ht = hd + hf + hsw + hb;
        int vt = vd + vf + vsw + vb;
        int p  = e / d;
        int px = p % ht;
        int py = (p / ht) % vt;
        int qx, qy;
        obs_t o;
        o.x    = 11'(px);
        o.y    = 11'(py);
        o.tick = (e % d) == (d - 1);
        o.von  = (px < hd) && (py < vd);
        o.fs   = (e > 0) && (e % (ht * vt * d) == 0);
        if (p == 0) begin
            o.hs  = 1'b1;
            o.vs  = 1'b1;
            o.col = 8'h00;
        end else begin
            qx    = (p - 1) % ht;
            qy    = ((p - 1) / ht) % vt;
            o.hs  = !((qx >= hd + hf) && (qx < hd + hf + hsw));
            o.vs  = !((qy >= vd + vf) && (qy < vd + vf + vsw));
            o.col = ((qx < hd) && (qy < vd)) ? smp : 8'h00;
        end
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s wait bound expired", nm);
    endtask

    // Called at a negedge; returns at the negedge where dut_a shows x==tx with
    // pix_tick high. rgb_in is scrambled on every clock it waits.
    task automatic wait_a(input logic [10:0] tx, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (tick_a && x_a == tx) begin
                ok = 1'b1;
                break;
            end
            rgb_in = 8'($urandom);
            @(negedge clk);
        end
    endtask

    vec_t tbl[9];

    initial begin
        int e;
        int ticks40;
        int cnt, n, first;
        bit ok;
        logic [7:0] r, pend_a, pend_b, smp_a, smp_b;
        logic [10:0] y0;
        obs_t rst_exp;

        tbl[0] = '{11'd400, 8'h48, 3'd0, 3'd1, 2'd1};
        tbl[1] = '{11'd500, 8'hFF, 3'd7, 3'd7, 2'd3};
        tbl[2] = '{11'd600, 8'hB3, 3'd3, 3'd6, 2'd2};
        tbl[3] = '{11'd639, 8'hFF, 3'd7, 3'd7, 2'd3};
        tbl[4] = '{11'd640, 8'hFF, 3'd0, 3'd0, 2'd0};
        tbl[5] = '{11'd700, 8'hFF, 3'd0, 3'd0, 2'd0};
        tbl[6] = '{11'd799, 8'hFF, 3'd0, 3'd0, 2'd0};
        tbl[7] = '{11'd0,   8'h6D, 3'd5, 3'd5, 2'd1};
        tbl[8] = '{11'd100, 8'h48, 3'd0, 3'd1, 2'd1};

        // Reset state, before any clock edge.
        #1 reset = 1'b1;
        #1;
        rst_exp = '{11'd0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
        chk("reset_a", 64'(obs_a()), 64'(rst_exp));
        chk("reset_b", 64'(obs_b()), 64'(rst_exp));

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Randomised colour against the raster model on both instances.
        e = 0; ticks40 = 0;
        pend_a = 8'h00; pend_b = 8'h00; smp_a = 8'h00; smp_b = 8'h00;
        for (int i = 0; i < 1300; i++) begin
            chk("model_a", 64'(obs_a()),
                64'(model(e, DA, HDA, HFA, HSA, HBA, VDA, VFA, VSA, VBA, smp_a)));
            chk("model_b", 64'(obs_b()),
                64'(model(e, DB, HDB, HFB, HSB, HBB, VDB, VFB, VSB, VBB, smp_b)));
            if (e < 40 && tick_a) ticks40++;
            r = 8'($urandom);
            rgb_in = r;
            if ((e + 1) % DA == 0) pend_a = r;
            if ((e + 1) % DB == 0) pend_b = r;
            @(negedge clk);
            e++;
            if (e % DA == 0) smp_a = pend_a;
            if (e % DB == 0) smp_b = pend_b;
        end
        chk("ticks_in_40clk", 64'(ticks40), 64'd10);

        // Colour mapping and blanking vectors, with scrambled rgb off-tick.
        foreach (tbl[k]) begin
            wait_a(tbl[k].tx, 3300, ok);
            if (!ok) begin
                timeout("vec_wait");
            end else begin
                rgb_in = tbl[k].rgb;
                @(negedge clk);
                chk("vec_pins", 64'({blue_a, green_a, red_a}),
                    64'({tbl[k].b, tbl[k].g, tbl[k].r}));
                rgb_in = 8'($urandom);
                @(negedge clk);
                rgb_in = 8'($urandom);
                @(negedge clk);
                chk("vec_hold", 64'({blue_a, green_a, red_a}),
                    64'({tbl[k].b, tbl[k].g, tbl[k].r}));
            end
        end

        // Line wrap, then hsync width and placement over one full line.
        wait_a(11'd799, 3300, ok);
        if (!ok) begin
            timeout("wrap_wait");
        end else begin
            y0 = y_a;
            @(negedge clk);
            chk("wrap_x", 64'(x_a), 64'd0);
            chk("wrap_y", 64'(y_a), 64'(y0 + 11'd1));
            cnt = 0;
            for (int i = 0; i < 800 * DA; i++) begin
                if (tick_a && !hsync_a) cnt++;
                if (tick_a && x_a == 11'd656) chk("hs_before", 64'(hsync_a), 64'd1);
                if (tick_a && x_a == 11'd657) chk("hs_first", 64'(hsync_a), 64'd0);
                if (tick_a && x_a == 11'd752) chk("hs_last", 64'(hsync_a), 64'd0);
                if (tick_a && x_a == 11'd753) chk("hs_after", 64'(hsync_a), 64'd1);
                @(negedge clk);
            end
            chk("hs_width", 64'(cnt), 64'd96);
        end

        // Frame period and vsync on the shrunken raster.
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLK_B; i++) begin
            if (fs_b) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            timeout("fs_wait");
        end else begin
            n = 0;
            ok = 1'b0;
            for (int i = 0; i < 2 * FRAME_CLK_B; i++) begin
                @(negedge clk);
                n++;
                if (fs_b) begin ok = 1'b1; break; end
            end
            chk("fs_period", 64'(n), 64'(FRAME_CLK_B));
            cnt = 0;
            for (int i = 0; i < FRAME_CLK_B; i++) begin
                if (tick_b && !vsync_b) cnt++;
                if (tick_b && x_b == 11'd0 && y_b == 11'd6) chk("vs_before", 64'(vsync_b), 64'd1);
                if (tick_b && x_b == 11'd1 && y_b == 11'd6) chk("vs_first", 64'(vsync_b), 64'd0);
                @(negedge clk);
            end
            chk("vs_width", 64'(cnt), 64'(VSB * (HDB + HFB + HSB + HBB)));
        end

        // Asynchronous reset in the middle of the hsync pulse.
        wait_a(11'd700, 3300, ok);
        if (!ok) begin
            timeout("arst_wait");
        end else begin
            rgb_in = 8'hFF;
            chk("arst_hs_low", 64'(hsync_a), 64'd0);
            #2 reset = 1'b1;
            #1;
            chk("arst_a", 64'({x_a, y_a, hsync_a, vsync_a, blue_a, green_a, red_a, fs_a}),
                64'({11'd0, 11'd0, 1'b1, 1'b1, 8'h00, 1'b0}));
            chk("arst_b", 64'({x_b, y_b, hsync_b, vsync_b, blue_b, green_b, red_b}),
                64'({11'd0, 11'd0, 1'b1, 1'b1, 8'h00}));
            @(negedge clk);
            reset = 1'b0;
            first = -1;
            for (int k = 0; k < 10; k++) begin
                if (tick_a) begin first = k; break; end
                @(negedge clk);
            end
            chk("first_tick_clk", 64'(first + 1), 64'd4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
